// File: rtl/logic_unit_pkg.sv
// Shared types for the 4-bit logic unit and its operand loader.
//   entry_state_e : operand-entry stage, encoded as shown on LEDG (0 = A .. 3 = ready)
//   func_e        : 2-bit logic-unit function select
package logic_unit_pkg;

    typedef enum logic [1:0] {
        StLoadA = 2'd0,
        StLoadB = 2'd1,
        StLoadF = 2'd2,
        StReady = 2'd3
    } entry_state_e;

    typedef enum logic [1:0] {
        FuncAnd = 2'd0,
        FuncOr  = 2'd1,
        FuncXor = 2'd2,
        FuncNor = 2'd3
    } func_e;

endpackage

// File: rtl/logic_operand_loader_if.sv
// Operand-entry bus between the switch/key front panel and the logic-unit loader.
//   SW, KEY_n              : shared entry value and active-low load key (panel -> loader)
//   A, B, F                : committed operand triple (loader -> logic unit)
//   op_valid, stage, commit: triple valid flag, entry stage for LEDG, commit pulse
// master = panel/consumer side, slave = loader side.
interface logic_operand_loader_if #(
    parameter int unsigned DATA_W = 4
);
    import logic_unit_pkg::*;

    logic [DATA_W-1:0] SW;
    logic              KEY_n;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    func_e             F;
    logic              op_valid;
    entry_state_e      stage;
    logic              commit;

    modport master (
        output SW, KEY_n,
        input  A, B, F, op_valid, stage, commit
    );

    modport slave (
        input  SW, KEY_n,
        output A, B, F, op_valid, stage, commit
    );

endinterface

// File: rtl/key_debounce.sv
// Synchronizer + debouncer for an asynchronous active-low push button.
//   clk_i, rst_i : clock, synchronous active-high reset
//   key_n_i      : raw key, active-low, asynchronous
//   level_o      : debounced key level (1 = released)
//   press_o      : one-cycle pulse on a debounced press (1 -> 0)
// A key held through reset never yields a press: presses are only armed once a
// full debounce window of released samples has been seen (needs DEBOUNCE_CYCLES > 2,
// since the two reset-value synchronizer samples read as released).
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o
);
    localparam int unsigned    RunW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [RunW-1:0] RunMax = RunW'(DEBOUNCE_CYCLES);

    logic            meta_q, sync_q, last_q;
    logic            level_q, level_d;
    logic            armed_q, armed_d;
    logic            press_q, press_d;
    logic [RunW-1:0] run_q, run_d;
    logic            stable;

    // run_q: length of the current run of identical synchronized samples, saturating.
    always_comb begin
        run_d = RunW'(1);
        if (sync_q == last_q) begin
            run_d = (run_q == RunMax) ? run_q : run_q + RunW'(1);
        end
        stable  = (run_d == RunMax);
        level_d = stable ? sync_q : level_q;
        armed_d = armed_q | (stable & sync_q);
        press_d = armed_q & stable & ~sync_q & level_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            last_q  <= 1'b1;
            run_q   <= '0;
            level_q <= 1'b1;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            meta_q  <= key_n_i;
            sync_q  <= meta_q;
            last_q  <= sync_q;
            run_q   <= run_d;
            level_q <= level_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/logic_operand_loader.sv
// Operand-entry stage for the 4-bit logic unit: captures A, B, then F from the shared
// switches on successive debounced key presses and commits the triple atomically.
//   CLOCK_50 : system clock
//   reset    : synchronous, active-high
//   bus      : slave side of logic_operand_loader_if (SW/KEY_n in; A/B/F/op_valid/stage/commit out)
// Optional: define ENTRY_TIMEOUT_EN to abort a partial entry after TIMEOUT_CYCLES idle
// cycles in LOAD_B/LOAD_F (committed outputs are kept).
module logic_operand_loader
    import logic_unit_pkg::*;
#(
    parameter int unsigned DATA_W          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
`ifdef ENTRY_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 250000000
`endif
) (
    input logic                   CLOCK_50,
    input logic                   reset,
    logic_operand_loader_if.slave bus
);
    entry_state_e      state_q, state_d;
    logic [DATA_W-1:0] shadow_a_q, shadow_a_d;
    logic [DATA_W-1:0] shadow_b_q, shadow_b_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    func_e             f_q, f_d;
    logic              valid_q, valid_d;
    logic              commit;
    logic              key_press, key_level, press;
    logic              timeout;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk_i  (CLOCK_50),
        .rst_i  (reset),
        .key_n_i(bus.KEY_n),
        .level_o(key_level),
        .press_o(key_press)
    );

    // A press always coincides with the debounced key being down.
    assign press = key_press & ~key_level;

`ifdef ENTRY_TIMEOUT_EN
    localparam int unsigned     IdleW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IdleW-1:0] IdleEnd = IdleW'(TIMEOUT_CYCLES - 1);

    logic [IdleW-1:0] idle_q, idle_d;

    always_comb begin
        idle_d  = idle_q;
        timeout = 1'b0;
        if (press || state_q == StLoadA || state_q == StReady) begin
            idle_d = '0;
        end else if (idle_q == IdleEnd) begin
            timeout = 1'b1;
            idle_d  = '0;
        end else begin
            idle_d = idle_q + IdleW'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        shadow_a_d = shadow_a_q;
        shadow_b_d = shadow_b_q;
        a_d        = a_q;
        b_d        = b_q;
        f_d        = f_q;
        valid_d    = valid_q;
        commit     = 1'b0;
        if (press) begin
            unique case (state_q)
                StLoadA: begin
                    shadow_a_d = bus.SW;
                    state_d    = StLoadB;
                end
                StLoadB: begin
                    shadow_b_d = bus.SW;
                    state_d    = StLoadF;
                end
                StLoadF: begin
                    a_d     = shadow_a_q;
                    b_d     = shadow_b_q;
                    f_d     = func_e'(bus.SW[1:0]);
                    valid_d = 1'b1;
                    commit  = 1'b1;
                    state_d = StReady;
                end
                StReady: state_d = StLoadA;
                default: state_d = StLoadA;
            endcase
        end else if (timeout) begin
            // Abandon the partial entry; the logic unit keeps its committed triple.
            state_d    = StLoadA;
            shadow_a_d = '0;
            shadow_b_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= StLoadA;
            shadow_a_q <= '0;
            shadow_b_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            f_q        <= FuncAnd;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_a_q <= shadow_a_d;
            shadow_b_q <= shadow_b_d;
            a_q        <= a_d;
            b_q        <= b_d;
            f_q        <= f_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.A        = a_q;
    assign bus.B        = b_q;
    assign bus.F        = f_q;
    assign bus.op_valid = valid_q;
    assign bus.stage    = state_q;
    assign bus.commit   = commit;

endmodule
